// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S widths and sample types
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  typedef logic signed [I2S_DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// rtl/i2s_transmitter_if.sv - stereo sample valid/ready handshake into the I2S transmitter
interface i2s_transmitter_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
);

  logic signed [DATA_W-1:0] left_data;
  logic signed [DATA_W-1:0] right_data;
  logic                     din_valid;
  logic                     din_ready;

  modport master (
    output left_data,
    output right_data,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  left_data,
    input  right_data,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/i2s_slot_counter.sv
// rtl/i2s_slot_counter.sv - slot/channel position counter for an I2S master frame
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(SLOT_W)-1:0] slot,
  output logic                      chan,
  output logic                      frame_last
);

  localparam int               CNT_W     = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_W - 1);

  // slot_q/chan_q name the position the next clock edge enters, so
  // registered outputs computed from them line up with that position.
  logic [CNT_W-1:0] slot_q, slot_d;
  logic             chan_q, chan_d;

  // Advance one slot; on slot wrap flip the channel.
  always_comb begin
    slot_d = slot_q + 1'b1;
    chan_d = chan_q;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      chan_d = ~chan_q;
    end
  end

  // Position state, parked at the start of a left slot while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      chan_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      chan_q <= chan_d;
    end
  end

  assign slot       = slot_q;
  assign chan       = chan_q;
  // Next edge enters L0: the current cycle closes a frame (or leaves reset).
  assign frame_last = (slot_q == '0) && !chan_q;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S master transmitter; I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic               sclk,
  input  logic               rst_n,
  i2s_transmitter_if.slave   din,
  output logic               lrclk,
  output logic               sdout,
  output logic               frame_start,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]        underrun_cnt,
`endif
  output logic               underrun
);

  localparam int               CNT_W     = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);

  logic [CNT_W-1:0] slot;
  logic             chan;
  logic             frame_last;

  i2s_slot_counter #(
    .SLOT_W (SLOT_W)
  ) u_slot_counter (
    .clk        (sclk),
    .rst_n      (rst_n),
    .slot       (slot),
    .chan       (chan),
    .frame_last (frame_last)
  );

  logic              lrclk_q, lrclk_d;
  logic              sdout_q, sdout_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              hold_empty_q, hold_empty_d;
  logic [DATA_W-1:0] hold_left_q, hold_left_d;
  logic [DATA_W-1:0] hold_right_q, hold_right_d;
  logic [DATA_W-1:0] left_sr_q, left_sr_d;
  logic [DATA_W-1:0] right_sr_q, right_sr_d;

  // lrclk_q is still 0 on the first edge out of reset, which keeps that
  // edge from being treated as a frame end (no commit, no underrun).
  logic frame_end;
  logic accept;
  logic commit;
  logic data_slot;

  assign frame_end = frame_last && lrclk_q;
  assign accept    = din.din_valid && hold_empty_q;
  assign commit    = frame_end && !hold_empty_q;
  assign data_slot = (slot != '0) && (slot <= DATA_LAST);

  // Next-state for framing outputs, holding register and rotating shifters.
  always_comb begin
    lrclk_d       = chan;
    frame_start_d = (slot == '0) && !chan;
    underrun_d    = frame_end && hold_empty_q;
    sdout_d       = 1'b0;
    hold_empty_d  = hold_empty_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    left_sr_d     = left_sr_q;
    right_sr_d    = right_sr_q;

    // Shifters rotate rather than drain so an underrun frame can resend
    // the same pair: DATA_W rotations return them to their loaded value.
    if (data_slot) begin
      if (!chan) begin
        sdout_d   = left_sr_q[DATA_W-1];
        left_sr_d = {left_sr_q[DATA_W-2:0], left_sr_q[DATA_W-1]};
      end else begin
        sdout_d    = right_sr_q[DATA_W-1];
        right_sr_d = {right_sr_q[DATA_W-2:0], right_sr_q[DATA_W-1]};
      end
    end

    if (commit) begin
      left_sr_d    = hold_left_q;
      right_sr_d   = hold_right_q;
      hold_empty_d = 1'b1;
    end else if (accept) begin
      hold_left_d  = din.left_data;
      hold_right_d = din.right_data;
      hold_empty_d = 1'b0;
    end
  end

  // Output, holding and shift registers; reset discards everything in flight.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      lrclk_q       <= 1'b0;
      sdout_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_empty_q  <= 1'b1;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      left_sr_q     <= '0;
      right_sr_q    <= '0;
    end else begin
      lrclk_q       <= lrclk_d;
      sdout_q       <= sdout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_empty_q  <= hold_empty_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      left_sr_q     <= left_sr_d;
      right_sr_q    <= right_sr_d;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Saturating count of underrun pulses, cleared only by reset.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign lrclk         = lrclk_q;
  assign sdout         = sdout_q;
  assign frame_start   = frame_start_q;
  assign underrun      = underrun_q;
  assign din.din_ready = hold_empty_q;

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S master transmitter for the pedal's output path (DSP core → DAC/codec).
- Runs entirely on the bit clock `sclk`, generates `lrclk`, and shifts stereo signed 24-bit samples MSB-first with the standard I2S one-bit delay after each `lrclk` edge.
- A single-entry holding register takes samples from the DSP through a valid/ready handshake. Held samples are committed to the wire once per stereo frame.

Parameters:
- DATA_W, 24, sample width in bits, signed two's complement.
- SLOT_W, 32, `sclk` cycles per channel slot; legal range DATA_W+1 to 64.

Ports:
- sclk  input  1  bit clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- left_data  input  DATA_W  signed left sample.
- right_data  input  DATA_W  signed right sample.
- din_valid  input  1  sample pair offered.
- din_ready  output  1  holding register empty; transfer when din_valid && din_ready.
- lrclk  output  1  word select; 0 = left slot, 1 = right slot.
- sdout  output  1  serial data.
- frame_start  output  1  one-cycle pulse in cycle L0.
- underrun  output  1  one-cycle pulse in L0 when no new sample was committed.

Behaviour:
- Frame timing:
  - Frame = left slot L0..L(SLOT_W-1), then right slot R0..R(SLOT_W-1), repeating.
  - lrclk = 0 throughout L, 1 throughout R.
  - All outputs are registered and change only on posedge sclk.
- Data placement:
  - L1..L(DATA_W) carry left[DATA_W-1] down to left[0].
  - R1..R(DATA_W) carry right[DATA_W-1] down to right[0].
  - All other cycles drive sdout = 0. This includes L0, R0 and the padding cycles.
  - A posedge-sampling receiver detecting the lrclk change in slot cycle 0 therefore reads the MSB in cycle 1.
- Handshake:
  - din_ready is 1 whenever the holding register is empty.
  - When din_valid && din_ready, both channels are captured and din_ready drops to 0 in the following cycle.
  - din_valid with din_ready = 0 is ignored; the source must hold valid.
- Commit:
  - In cycle R(SLOT_W-1), if the holding register is full, its contents load the left/right shift registers, the register empties, and din_ready = 1 from L0.
  - A transfer accepted in R(SLOT_W-1) itself is not committed in that cycle; it waits for the next frame.
- Underrun:
  - If the holding register is empty at R(SLOT_W-1), the previous sample pair is retransmitted unchanged and underrun pulses in L0.
- Counters:
  - slot counter 0..SLOT_W-1 wraps to 0 and toggles the channel bit.
  - No other state.
- Reset values:
  - lrclk = 0, sdout = 0, frame_start = 0, underrun = 0, din_ready = 1.
  - Shift registers = 0, holding register empty.
  - The first cycle after rst_n rises is L0. The first frame transmits zeros, with frame_start = 1 and no underrun.
- Reset mid-frame: takes effect at the next posedge, discards any held or in-flight sample, and restarts the frame at L0 on release.
- Sign: no sign extension or truncation; exactly DATA_W bits are sent.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0]:
  - increments on each underrun pulse;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package i2s_pkg holds:
  - I2S_DATA_W = 24 and I2S_SLOT_W = 32 defaults;
  - typedef sample_t (logic signed [23:0]);
  - struct stereo_t {left, right}.
- i2s_receiver is later migrated to this package.
- One sub-module: i2s_slot_counter. It produces the slot index, the channel bit and the last-cycle-of-frame strobe, and is reusable for a future master-mode receiver.

Test Plan:
- Reset, then hold din_valid = 0 for 2 frames → frame 1: sdout all 0, lrclk period 64 cycles, frame_start every 64 cycles; frame 2: underrun pulses at L0.
- Offer left = 24'h800001, right = 24'h7FFFFF before R31 → next frame: L1..L24 = 1,0×22,1; R1..R24 = 0,1×23; L25..L31 = 0.
- Offer one pair per frame for 8 frames → zero underruns; each frame carries that frame's values; din_ready returns to 1 at every L0.
- Hold din_valid with a new pair while the register is full → din_ready = 0; pair accepted in L0; sent one frame later, none lost or duplicated.
- Assert rst_n = 0 at R10 with a sample held → next cycle all outputs at reset values; after release the held sample is not transmitted and the frame starts at L0.
- With I2S_TX_UNDERRUN_CNT_EN, starve for 5 frames after one sample → underrun_cnt = 5 (first frame excluded); last sample repeated on the wire.
